// File: rtl/fifo_umbral_pkg.sv
// Shared sizing constants for fifo_umbral and the flow-control state machine.
package fifo_umbral_pkg;
  localparam int DATA_WIDTH_DEF = 6;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam int DEPTH_DEF      = 1 << ADDR_WIDTH_DEF;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction
endpackage

// File: rtl/fifo_umbral_if.sv
// Handshake/status bundle between fifo_umbral and its producer/consumer.
interface fifo_umbral_if
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();
  logic [DATA_WIDTH-1:0] data_in;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] umbral_superior;
  logic [ADDR_WIDTH-1:0] umbral_inferior;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  error;

  modport master (
    output data_in, push, pop, umbral_superior, umbral_inferior,
    input  data_out, valid, empty, full, almost_full, almost_empty, error
  );

  modport slave (
    input  data_in, push, pop, umbral_superior, umbral_inferior,
    output data_out, valid, empty, full, almost_full, almost_empty, error
  );
endinterface

// File: rtl/fifo_umbral_memoria_dp.sv
// Simple dual-port storage: one write port, one registered read port.
module memoria_dp
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto plain RAM; stale words are never visible because the pointers are reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read-before-write: a read and write to the same slot return the old word.
  always_ff @(posedge clk) begin
    if (!reset)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/fifo_umbral.sv
// Threshold FIFO with registered read and programmable almost-full/empty flags.
// Optional sticky overflow/underflow flag: define FIFO_UMBRAL_ERROR_EN.
module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input logic          clk,
  input logic          reset,
  fifo_umbral_if.slave bus
);
  localparam int                  DEPTH     = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  valid_q;
  logic                  push_ok, pop_ok;

  // Flags depend only on registered count and the thresholds.
  assign bus.empty        = (count_q == '0);
  assign bus.full         = (count_q == DEPTH_CNT);
  assign bus.almost_full  = (count_q >= {1'b0, bus.umbral_superior});
  assign bus.almost_empty = (count_q <= {1'b0, bus.umbral_inferior});

  assign pop_ok  = reset && bus.pop && !bus.empty;
  assign push_ok = reset && bus.push && (!bus.full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= pop_ok;
    end
  end

  assign bus.valid = valid_q;

  memoria_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (push_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .re_i    (pop_ok),
    .raddr_i (rd_ptr_q),
    .rdata_o (bus.data_out)
  );

`ifdef FIFO_UMBRAL_ERROR_EN
  logic error_q, error_d;

  always_comb begin
    error_d = error_q;
    if (bus.push && bus.full && !pop_ok) error_d = 1'b1;
    if (bus.pop && bus.empty)            error_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) error_q <= 1'b0;
    else        error_q <= error_d;
  end

  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_umbral.sv
// Directed bench for fifo_umbral with a queue-based reference model and scoreboard.
module tb_fifo_umbral;
  logic clk;
  logic reset;

  fifo_umbral_if bus ();

  fifo_umbral dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [5:0] mdl [$];      // reference contents
  logic [5:0] exp_q [$];    // scoreboard of words awaiting read-out
  logic [5:0] last_data;
  logic       err_m;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    int n;
    n = mdl.size();
    check({tag, ".empty"},  8'(bus.empty),        8'(n == 0));
    check({tag, ".full"},   8'(bus.full),         8'(n == 8));
    check({tag, ".afull"},  8'(bus.almost_full),  8'(n >= int'(bus.umbral_superior)));
    check({tag, ".aempty"}, 8'(bus.almost_empty), 8'(n <= int'(bus.umbral_inferior)));
    check({tag, ".error"},  8'(bus.error),        8'(err_m));
  endtask

  task automatic step(input logic ps, input logic pp, input logic [5:0] din, input string tag);
    logic m_pop, m_push;
    @(negedge clk);
    bus.push    = ps;
    bus.pop     = pp;
    bus.data_in = din;
    m_pop  = pp && (mdl.size() != 0);
    m_push = ps && ((mdl.size() < 8) || m_pop);
`ifdef FIFO_UMBRAL_ERROR_EN
    if ((ps && mdl.size() == 8 && !m_pop) || (pp && mdl.size() == 0)) err_m = 1'b1;
`endif
    if (m_pop)  exp_q.push_back(mdl.pop_front());
    if (m_push) mdl.push_back(din);
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 8'(bus.valid), 8'(m_pop));
    if (m_pop) last_data = exp_q.pop_front();
    check({tag, ".data"}, 8'(bus.data_out), 8'(last_data));
    check_flags(tag);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset       = 1'b0;
    bus.push    = 1'b1;
    bus.pop     = 1'b1;
    bus.data_in = 6'h2A;
    @(posedge clk);
    #1;
    mdl.delete();
    exp_q.delete();
    last_data = '0;
    err_m     = 1'b0;
    check({tag, ".valid"}, 8'(bus.valid), 8'h00);
    check({tag, ".data"},  8'(bus.data_out), 8'h00);
    check_flags(tag);
    @(negedge clk);
    reset    = 1'b1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.data_in = '0;
    bus.umbral_superior = 3'd0;
    bus.umbral_inferior = 3'd2;
    last_data = '0;
    err_m = 1'b0;

    // Reset with upper threshold 0: almost_full must read 1.
    do_reset("rst_thr0");
    check("rst_thr0.af_forced", 8'(bus.almost_full), 8'h01);

    // Threshold change is visible in the same cycle.
    bus.umbral_superior = 3'd6;
    #1;
    check("thr_change.af", 8'(bus.almost_full), 8'h00);
    step(1'b0, 1'b0, 6'h00, "idle0");

    // Fill 0x01..0x08.
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 6'(i), $sformatf("fill%0d", i));
    check("fill.full", 8'(bus.full), 8'h01);

    // Full: push+pop both accepted, 0x01 out, 0x3F in, pointers wrap.
    step(1'b1, 1'b1, 6'h3F, "full_pp");
    // Full: push alone is dropped.
    step(1'b1, 1'b0, 6'h15, "full_drop");
    step(1'b0, 1'b0, 6'h00, "idle1");

    // Drain: expect 0x02..0x08 then 0x3F as the 8th read.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 6'h00, $sformatf("drain%0d", i));
    check("drain.last", 8'(bus.data_out), 8'h3F);
    check("drain.empty", 8'(bus.empty), 8'h01);

    // Empty: pop ignored.
    step(1'b0, 1'b1, 6'h00, "empty_pop");
    step(1'b0, 1'b0, 6'h00, "idle2");

    // Empty: push+pop -> only push accepted, no fall-through.
    do_reset("rst2");
    step(1'b1, 1'b1, 6'h2B, "empty_pp");
    step(1'b0, 1'b1, 6'h00, "empty_pp_read");
    check("empty_pp_read.word", 8'(bus.data_out), 8'h2B);

    // Lower threshold 0: almost_empty follows count==0.
    bus.umbral_inferior = 3'd0;
    step(1'b1, 1'b0, 6'h11, "thr0_push");
    step(1'b0, 1'b1, 6'h00, "thr0_pop");
    bus.umbral_inferior = 3'd2;

    // Mid-stream reset at count 5, after an error to confirm it clears.
    step(1'b0, 1'b1, 6'h00, "pre_err");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'(6'h20 + i), $sformatf("mid%0d", i));
    do_reset("rst_mid");
    step(1'b0, 1'b1, 6'h00, "post_rst_pop");
    step(1'b1, 1'b0, 6'h07, "post_rst_push");
    step(1'b0, 1'b1, 6'h00, "post_rst_read");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fifo_umbral.md
FIFO_UMBRAL -- requirements
Module: fifo_umbral

Interface
REQ-001 Parameter DATA_WIDTH, default 6: payload width per entry.
REQ-002 Parameter ADDR_WIDTH, default 3: pointer width; depth = 2**ADDR_WIDTH (8).
REQ-003 Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- data_in  in  DATA_WIDTH  write payload.
- push  in  1  write request.
- pop  in  1  read request.
- umbral_superior  in  ADDR_WIDTH  almost-full threshold, from the flow-control state machine.
- umbral_inferior  in  ADDR_WIDTH  almost-empty threshold, from the flow-control state machine.
- data_out  out  DATA_WIDTH  registered read payload.
- valid  out  1  data_out holds a popped word this cycle.
- empty  out  1  count == 0; drives the state machine's empty input.
- full  out  1  count == depth.
- almost_full  out  1  count >= umbral_superior.
- almost_empty  out  1  count <= umbral_inferior.
- error  out  1  overflow/underflow flag (see Configuration).

Function
REQ-004 count SHALL be ADDR_WIDTH+1 bits, range 0..depth; wr_ptr and rd_ptr SHALL be ADDR_WIDTH bits and wrap modulo depth.
REQ-005 A push is accepted when push=1 and (full=0, or pop is also accepted in the same cycle); the word is written at wr_ptr and wr_ptr increments.
REQ-006 A pop is accepted when pop=1 and empty=0; the next cycle data_out = mem[rd_ptr], valid=1, and rd_ptr increments. Read latency is exactly 1 cycle.
REQ-007 valid SHALL be 0 in any cycle following no accepted pop; data_out holds its last value.
REQ-008 Simultaneous accepted push and pop: count unchanged, both pointers advance.
REQ-009 When full, push+pop: both accepted, count stays depth.
REQ-010 When empty, push+pop: push accepted, pop ignored (no fall-through); count becomes 1; valid=0 next cycle.
REQ-011 Push while full without pop: dropped, memory and pointers unchanged. Pop while empty: ignored.
REQ-012 empty, full, almost_full and almost_empty SHALL decode combinationally from registered count and the threshold inputs only, with no combinational path from push, pop or data_in.
REQ-013 A threshold change takes effect on the flags in the same cycle; threshold 0 gives almost_full=1 and almost_empty=(count==0).

Reset
REQ-014 While reset=0 at a clock edge: count=0, wr_ptr=0, rd_ptr=0, data_out=0, valid=0, error=0. Flags then read empty=1, full=0, almost_full=(umbral_superior==0), almost_empty=1.
REQ-015 Reset asserted mid-operation SHALL discard all stored words; memory contents need not be cleared.
REQ-016 push and pop asserted during reset are ignored.

Configuration
REQ-017 Macro FIFO_UMBRAL_ERROR_EN.
- Defined: error sets on a dropped push (REQ-011, full) or an ignored pop while empty, and is sticky until reset.
- Undefined: error is tied to 0 and no error logic is synthesized.

Structure
REQ-018 A shared package SHALL hold the DATA_WIDTH and ADDR_WIDTH defaults and the derived depth constant, used by this block and by the flow-control state machine.
REQ-019 Storage SHALL be a sub-module memoria_dp: 1 write port, 1 registered read port, no reset on the array.
REQ-020 Pointer, count and flag logic stays in fifo_umbral.

Verification
REQ-021 Reset, then 8 pushes of 0x01..0x08 -> full=1 after the 8th; almost_full=1 from count 6 with umbral_superior=6.
REQ-022 From full, 8 pops -> data_out 0x01..0x08 in order, each 1 cycle after its pop; empty=1 after the last; almost_empty=1 at count<=2 with umbral_inferior=2.
REQ-023 Full FIFO, push 0x3F+pop same cycle -> count stays 8, pointers wrap, 0x3F later read out 8th.
REQ-024 Empty FIFO, push+pop same cycle -> count=1, valid=0; then pop -> valid=1 with the pushed word.
REQ-025 Push when full / pop when empty -> no state change; error=1 and sticky with FIFO_UMBRAL_ERROR_EN, error=0 without it.
REQ-026 Reset=0 mid-stream at count 5 -> next cycle count=0, empty=1, valid=0, error=0.
